cal_date_keeper: RTL and testbench

Parametrised date keeper for the digital clock: holds day, month and year and rolls them over with leap-year rules. The date advances from a single-cycle midnight pulse supplied by the time-of-day counter, and can be set from four push buttons while the set switch is low. It drives BCD digits for the display mux and carries its own button synchronisers and edge detectors.

---
 rtl/cal_date_keeper.sv | 191 +++++++++++++++++++
 tb/tb_cal_date_keeper.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_date_keeper.sv
// -----------------------------------------------------------------------------
// cal_date_keeper
//
// Date keeper for the digital clock. Holds day, month and year as binary
// registers and rolls them over with (optionally Gregorian) leap-year rules.
// The date advances on the midnight pulse from the time-of-day counter while
// in run mode, or is edited from four push buttons while in set mode. Every
// path through the next-state logic keeps the held date valid.
//
// Parameters:
//   YEAR_BASE   lowest representable year
//   YEAR_SPAN   number of years before the year wraps back to YEAR_BASE
//   RESET_YEAR  year loaded on reset and on restore
//   RESET_MONTH month loaded on reset and on restore (1..12)
//   RESET_DAY   day loaded on reset and on restore (valid for the above)
//   LEAP_EN     1 = Gregorian leap rule, 0 = February always has 28 days
//
// Ports:
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   enb        run enable; day_tick is ignored while low
//   sw1        0 = set mode (buttons act), 1 = run mode (day_tick acts)
//   day_tick   single-cycle midnight pulse, synchronous to clk
//   btn[3:0]   raw buttons: [0] day+, [1] month+, [2] year+, [3] restore
//   dd1, dd2   day tens / units, BCD
//   mm1, mm2   month tens / units, BCD
//   yy1..yy4   year thousands / hundreds / tens / units, BCD
//   new_day    one-cycle pulse after each tick-driven advance
//   year_wrap  one-cycle pulse when the year wraps to YEAR_BASE
// -----------------------------------------------------------------------------
module cal_date_keeper #(
   parameter int YEAR_BASE   = 2000,
   parameter int YEAR_SPAN   = 100,
   parameter int RESET_YEAR  = 2022,
   parameter int RESET_MONTH = 1,
   parameter int RESET_DAY   = 1,
   parameter int LEAP_EN     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enb,
   input  logic       sw1,
   input  logic       day_tick,
   input  logic [3:0] btn,
   output logic [3:0] dd1,
   output logic [3:0] dd2,
   output logic [3:0] mm1,
   output logic [3:0] mm2,
   output logic [3:0] yy1,
   output logic [3:0] yy2,
   output logic [3:0] yy3,
   output logic [3:0] yy4,
   output logic       new_day,
   output logic       year_wrap
);

   localparam logic [13:0] YEAR_MIN = 14'(YEAR_BASE);
   localparam logic [13:0] YEAR_TOP = 14'(YEAR_BASE + YEAR_SPAN - 1);
   localparam logic [13:0] YEAR_RST = 14'(RESET_YEAR);
   localparam logic [3:0]  MONTH_RST = 4'(RESET_MONTH);
   localparam logic [4:0]  DAY_RST   = 5'(RESET_DAY);

   // ---------------------------------------------------------------------------
   // Calendar helpers
   // ---------------------------------------------------------------------------
   function automatic logic is_leap(input logic [13:0] y);
      return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) ||
             ((y % 14'd400) == 14'd0);
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0]  m,
                                                input logic [13:0] y);
      logic [4:0] d;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         4'd2:                    d = ((LEAP_EN != 0) && is_leap(y)) ? 5'd29 : 5'd28;
         default:                 d = 5'd31;
      endcase
      return d;
   endfunction

   function automatic logic [13:0] next_year(input logic [13:0] y);
      return (y == YEAR_TOP) ? YEAR_MIN : y + 14'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [4:0]  day,   day_n;
   logic [3:0]  month, month_n;
   logic [13:0] year,  year_n;
   logic        new_day_n;
   logic        year_wrap_n;

   // Button synchroniser (sync1, sync2) and edge-detect (sync3) flops.
   logic [3:0]  sync1, sync2, sync3;
   logic [3:0]  press;

   assign press = sync2 & ~sync3;

   // ---------------------------------------------------------------------------
   // Next-state logic. Buttons only act in set mode, the tick only in run mode,
   // so a tick and a button edge can never both act in the same cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave one unassigned and infer a latch.
      day_n       = day;
      month_n     = month;
      year_n      = year;
      new_day_n   = 1'b0;
      year_wrap_n = 1'b0;

      if (!sw1) begin
         // Fixed priority: restore > year+ > month+ > day+; the rest are dropped.
         if (press[3]) begin
            day_n   = DAY_RST;
            month_n = MONTH_RST;
            year_n  = YEAR_RST;
         end else if (press[2]) begin
            year_n      = next_year(year);
            year_wrap_n = (year == YEAR_TOP);
            // Feb 29 becomes Feb 28 when the new year is not leap.
            if (day > days_in_month(month, year_n))
               day_n = days_in_month(month, year_n);
         end else if (press[1]) begin
            month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
            if (day > days_in_month(month_n, year))
               day_n = days_in_month(month_n, year);
         end else if (press[0]) begin
            // Day+ wraps within the month and never carries.
            day_n = (day >= days_in_month(month, year)) ? 5'd1 : day + 5'd1;
         end
      end else if (day_tick && enb) begin
         new_day_n = 1'b1;
         if (day >= days_in_month(month, year)) begin
            day_n = 5'd1;
            if (month == 4'd12) begin
               month_n     = 4'd1;
               year_n      = next_year(year);
               year_wrap_n = (year == YEAR_TOP);
            end else begin
               month_n = month + 4'd1;
            end
         end else begin
            day_n = day + 5'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers. The synchronisers keep sampling in run mode so that switching
   // back to set mode never releases a stale edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '0;
         sync2     <= '0;
         sync3     <= '0;
         day       <= DAY_RST;
         month     <= MONTH_RST;
         year      <= YEAR_RST;
         new_day   <= 1'b0;
         year_wrap <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values from
         // before this edge, which is what makes the synchroniser a shift chain.
         sync1     <= btn;
         sync2     <= sync1;
         sync3     <= sync2;
         day       <= day_n;
         month     <= month_n;
         year      <= year_n;
         new_day   <= new_day_n;
         year_wrap <= year_wrap_n;
      end
   end

   // ---------------------------------------------------------------------------
   // BCD display digits, decoded straight from the binary registers.
   // ---------------------------------------------------------------------------
   assign dd1 = 4'(day / 5'd10);
   assign dd2 = 4'(day % 5'd10);
   assign mm1 = 4'(month / 4'd10);
   assign mm2 = 4'(month % 4'd10);
   assign yy1 = 4'((year / 14'd1000) % 14'd10);
   assign yy2 = 4'((year / 14'd100) % 14'd10);
   assign yy3 = 4'((year / 14'd10) % 14'd10);
   assign yy4 = 4'(year % 14'd10);

endmodule

// File: tb/tb_cal_date_keeper.sv
// -----------------------------------------------------------------------------
// tb_cal_date_keeper
//
// Directed bench for cal_date_keeper. Two instances share all inputs: dut_a
// with the Gregorian leap rule and dut_b with LEAP_EN=0, so leap-specific
// behaviour shows up as a difference between them. Expected dates are written
// as BCD constants {yyyy, mm, dd}; each step pushes its expectation into a
// scoreboard queue and the comparison pops it once the DUTs have responded.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cal_date_keeper;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enb;
   logic       sw1;
   logic       day_tick;
   logic [3:0] btn;

   logic [3:0] dd1_a, dd2_a, mm1_a, mm2_a, yy1_a, yy2_a, yy3_a, yy4_a;
   logic [3:0] dd1_b, dd2_b, mm1_b, mm2_b, yy1_b, yy2_b, yy3_b, yy4_b;
   logic       new_day_a, year_wrap_a, new_day_b, year_wrap_b;

   always #5 clk = ~clk;

   cal_date_keeper dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .enb       (enb),
      .sw1       (sw1),
      .day_tick  (day_tick),
      .btn       (btn),
      .dd1       (dd1_a),
      .dd2       (dd2_a),
      .mm1       (mm1_a),
      .mm2       (mm2_a),
      .yy1       (yy1_a),
      .yy2       (yy2_a),
      .yy3       (yy3_a),
      .yy4       (yy4_a),
      .new_day   (new_day_a),
      .year_wrap (year_wrap_a)
   );

   cal_date_keeper #(.LEAP_EN(0)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .enb       (enb),
      .sw1       (sw1),
      .day_tick  (day_tick),
      .btn       (btn),
      .dd1       (dd1_b),
      .dd2       (dd2_b),
      .mm1       (mm1_b),
      .mm2       (mm2_b),
      .yy1       (yy1_b),
      .yy2       (yy2_b),
      .yy3       (yy3_b),
      .yy4       (yy4_b),
      .new_day   (new_day_b),
      .year_wrap (year_wrap_b)
   );

   logic [31:0] date_a, date_b;
   logic [3:0]  pulses;

   assign date_a = {yy1_a, yy2_a, yy3_a, yy4_a, mm1_a, mm2_a, dd1_a, dd2_a};
   assign date_b = {yy1_b, yy2_b, yy3_b, yy4_b, mm1_b, mm2_b, dd1_b, dd2_b};
   assign pulses = {new_day_a, year_wrap_a, new_day_b, year_wrap_b};

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      string       tag;
      logic [31:0] date_a;
      logic [31:0] date_b;
      logic [3:0]  pulses;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic sb_push2(input string tag, input logic [31:0] ea,
                           input logic [31:0] eb, input logic nd, input logic yw);
      exp_t e;
      e.tag    = tag;
      e.date_a = ea;
      e.date_b = eb;
      e.pulses = {nd, yw, nd, yw};
      sb.push_back(e);
   endtask

   task automatic sb_push(input string tag, input logic [31:0] ed,
                          input logic nd, input logic yw);
      sb_push2(tag, ed, ed, nd, yw);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard_empty: observed no pending entry, required one");
      end else begin
         e = sb.pop_front();
         n_checks++;
         assert ({date_a, date_b} === {e.date_a, e.date_b}) else begin
            n_errors++;
            $error("FAIL %s date: observed a=%h b=%h, expected a=%h b=%h",
                   e.tag, date_a, date_b, e.date_a, e.date_b);
         end
         n_checks++;
         assert (pulses === e.pulses) else begin
            n_errors++;
            $error("FAIL %s pulses {nd_a,yw_a,nd_b,yw_b}: observed %b, expected %b",
                   e.tag, pulses, e.pulses);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic step();
      @(negedge clk);
   endtask

   // Press, hold long enough to act (date changes on the 3rd edge), release.
   task automatic press(input logic [3:0] mask);
      btn = mask;
      repeat (3) step();
      btn = 4'b0000;
      repeat (3) step();
   endtask

   task automatic press_n(input logic [3:0] mask, input int n);
      for (int i = 0; i < n; i++) press(mask);
   endtask

   // One-cycle tick; returns just after the edge that consumed it.
   task automatic tick();
      day_tick = 1'b1;
      step();
      day_tick = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_n    = 1'b0;
      enb      = 1'b1;
      sw1      = 1'b0;
      day_tick = 1'b0;
      btn      = 4'b0000;
      repeat (2) step();

      sb_push("in_reset", 32'h2022_0101, 1'b0, 1'b0);
      sb_check();
      rst_n = 1'b1;
      step();
      sb_push("after_reset", 32'h2022_0101, 1'b0, 1'b0);
      sb_check();

      // Set 2023-02-28 with the buttons, then roll into March.
      sb_push("set_2023_02_28", 32'h2023_0228, 1'b0, 1'b0);
      press(4'b0100);
      press(4'b0010);
      press_n(4'b0001, 27);
      sb_check();

      sw1 = 1'b1;
      step();
      sb_push("tick_2023_feb", 32'h2023_0301, 1'b1, 1'b0);
      tick();
      sb_check();
      sb_push("new_day_one_cycle", 32'h2023_0301, 1'b0, 1'b0);
      step();
      sb_check();

      // 2024-02-28, then two back-to-back ticks.
      sw1 = 1'b0;
      step();
      sb_push("set_2024_02_28", 32'h2024_0228, 1'b0, 1'b0);
      press(4'b0100);
      press_n(4'b0010, 11);
      press_n(4'b0001, 27);
      sb_check();

      sw1 = 1'b1;
      step();
      sb_push2("tick_leap_1", 32'h2024_0229, 32'h2024_0301, 1'b1, 1'b0);
      sb_push2("tick_leap_2", 32'h2024_0301, 32'h2024_0302, 1'b1, 1'b0);
      sb_push2("tick_leap_idle", 32'h2024_0301, 32'h2024_0302, 1'b0, 1'b0);
      day_tick = 1'b1;
      step();
      sb_check();
      step();
      day_tick = 1'b0;
      sb_check();
      step();
      sb_check();

      // Simultaneous presses: highest priority wins, the rest are dropped.
      sw1 = 1'b0;
      step();
      sb_push("restore_over_day", 32'h2022_0101, 1'b0, 1'b0);
      press(4'b1001);
      sb_check();
      sb_push("year_over_month", 32'h2023_0101, 1'b0, 1'b0);
      press(4'b0110);
      sb_check();

      // Month and year changes clamp the day.
      sb_push("set_2024_01_31", 32'h2024_0131, 1'b0, 1'b0);
      press(4'b0100);
      press_n(4'b0001, 30);
      sb_check();
      sb_push2("month_clamp", 32'h2024_0229, 32'h2024_0228, 1'b0, 1'b0);
      press(4'b0010);
      sb_check();
      sb_push("year_clamp", 32'h2025_0228, 1'b0, 1'b0);
      press(4'b0100);
      sb_check();
      sb_push("day_wrap_no_carry", 32'h2025_0201, 1'b0, 1'b0);
      press(4'b0001);
      sb_check();

      // Held button: acts once, on the second edge after it is seen.
      sb_push("held_edge_n1", 32'h2025_0201, 1'b0, 1'b0);
      sb_push("held_edge_n2", 32'h2025_0202, 1'b0, 1'b0);
      sb_push("held_100", 32'h2025_0202, 1'b0, 1'b0);
      btn = 4'b0001;
      repeat (2) step();
      sb_check();
      step();
      sb_check();
      repeat (97) step();
      sb_check();
      btn = 4'b0000;
      repeat (3) step();

      // 2099-12-31 and the year wrap on a tick.
      sb_push("set_2099_12_31", 32'h2099_1231, 1'b0, 1'b0);
      press_n(4'b0010, 10);
      press_n(4'b0001, 29);
      press_n(4'b0100, 74);
      sb_check();

      sw1 = 1'b1;
      step();
      sb_push("tick_year_wrap", 32'h2000_0101, 1'b1, 1'b1);
      tick();
      sb_check();
      sb_push("wrap_one_cycle", 32'h2000_0101, 1'b0, 1'b0);
      step();
      sb_check();

      // Tick with enb low, then buttons in run mode: neither may act.
      enb = 1'b0;
      sb_push("tick_enb_low", 32'h2000_0101, 1'b0, 1'b0);
      tick();
      sb_check();
      enb = 1'b1;
      sb_push("run_mode_buttons", 32'h2000_0101, 1'b0, 1'b0);
      press(4'b0001);
      press(4'b0100);
      press(4'b1000);
      sb_check();

      sb_push("tick_2000_01_02", 32'h2000_0102, 1'b1, 1'b0);
      tick();
      sb_check();
      step();

      // Reset in the middle of a press: immediate restore, no late press.
      sw1 = 1'b0;
      btn = 4'b0001;
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      sb_push("async_reset", 32'h2022_0101, 1'b0, 1'b0);
      sb_check();
      btn = 4'b0000;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (4) step();
      sb_push("no_spurious_press", 32'h2022_0101, 1'b0, 1'b0);
      sb_check();

      sb_push("alive_after_reset", 32'h2022_0102, 1'b0, 1'b0);
      press(4'b0001);
      sb_check();

      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard_drain: observed %0d pending entries, required 0",
                sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
